spi_tx_scheduler: RTL

- Shares one SPI mode-0 transmit link (sclk/mosi/cs_n) between N_REQ byte requesters, e.g. the button-trigger path and a periodic status source.
- Round-robin arbitration picks one requester per frame. The block sequences chip-select setup, shift and hold timing, then enforces an inter-frame gap.
- Sits between requester logic and the board's SPI pins; it is the only driver of sclk/mosi/cs_n.

---
 rtl/spi_sched_pkg.sv | 19 +
 rtl/spi_tx_scheduler_shifter.sv | 73 +++++++
 rtl/spi_tx_scheduler.sv | 124 ++++++++++++
 3 files changed

// File: rtl/spi_sched_pkg.sv
// Shared types and helpers for the SPI transmit scheduler.
package spi_sched_pkg;

  localparam int MAX_REQ = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  // One-hot vector with bit idx set; callers size-cast to their requester count.
  function automatic logic [MAX_REQ-1:0] onehot(input int idx);
    return {{(MAX_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/spi_tx_scheduler_shifter.sv
// Mode-0 byte shifter: drives sclk/mosi MSB first, CLK_DIV clk cycles per half-period.
module spi_byte_shifter #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              start,
  input  logic              clear,
  input  logic [DATA_W-1:0] data,
  output logic              sclk,
  output logic              mosi,
  output logic              last_bit_done
);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_W);

  // MSB lives in mosi after load; only the remaining bits are held here.
  logic [DATA_W-2:0] rest;
  logic              active;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              phase_end;

  assign phase_end     = active && (div_cnt == DIV_W'(CLK_DIV - 1));
  // Combinational so the FSM leaves SHIFT on the same edge sclk falls for the last time.
  assign last_bit_done = phase_end && sclk && (bit_cnt == BIT_W'(DATA_W - 1));

  // Half-period timing, bit counting and MSB-first data shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rest    <= '0;
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else if (load) begin
      rest    <= data[DATA_W-2:0];
      mosi    <= data[DATA_W-1];
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
    end else if (clear) begin
      mosi <= 1'b0;
    end else if (start) begin
      active  <= 1'b1;
      div_cnt <= '0;
    end else if (active) begin
      if (phase_end) begin
        div_cnt <= '0;
        if (!sclk) begin
          sclk <= 1'b1;
        end else begin
          // mosi only moves on the falling edge, so it is stable at every rise.
          sclk <= 1'b0;
          if (bit_cnt == BIT_W'(DATA_W - 1)) begin
            active <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            mosi    <= rest[DATA_W-2];
            rest    <= rest << 1;
          end
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_tx_scheduler.sv
// Round-robin arbiter sharing one SPI mode-0 transmit link between N_REQ requesters.
module spi_tx_scheduler
  import spi_sched_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int DATA_W   = 8,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int IDLE_GAP = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy,
  output logic                      done,
  output logic                      sclk,
  output logic                      mosi,
  output logic                      cs_n
);
  localparam int IW    = $clog2(N_REQ);
  localparam int TM_A  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int TM_B  = (CS_HOLD > IDLE_GAP) ? CS_HOLD : IDLE_GAP;
  localparam int TMAX  = (TM_A > TM_B) ? TM_A : TM_B;
  localparam int TW    = $clog2(TMAX + 1);

  state_t            state;
  logic [IW-1:0]     rr_ptr;
  logic [TW-1:0]     tmr;
  logic              gnt_found;
  logic [IW-1:0]     gnt_idx;
  logic [IW-1:0]     cand;
  logic              sh_load, sh_start, sh_clear, sh_last;
  logic [DATA_W-1:0] load_data;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IW'((int'(rr_ptr) + k) % N_REQ);
      if (req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign load_data = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
  assign sh_load   = (state == IDLE)  && gnt_found;
  assign sh_start  = (state == SETUP) && (tmr == TW'(CS_SETUP - 1));
  assign sh_clear  = (state == HOLD)  && (tmr == TW'(CS_HOLD - 1));

  spi_byte_shifter #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) u_shifter (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (sh_load),
    .start         (sh_start),
    .clear         (sh_clear),
    .data          (load_data),
    .sclk          (sclk),
    .mosi          (mosi),
    .last_bit_done (sh_last)
  );

  // Frame sequencer: grant, cs setup, shift, cs hold, inter-frame gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= IW'(N_REQ - 1);
      tmr       <= '0;
      grant_id  <= '0;
      req_ready <= '0;
      cs_n      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      req_ready <= '0;
      done      <= 1'b0;
      case (state)
        IDLE: if (gnt_found) begin
          rr_ptr    <= gnt_idx;
          grant_id  <= gnt_idx;
          req_ready <= N_REQ'(onehot(int'(gnt_idx)));
          cs_n      <= 1'b0;
          busy      <= 1'b1;
          tmr       <= '0;
          state     <= SETUP;
        end
        SETUP: if (tmr == TW'(CS_SETUP - 1)) begin
          tmr   <= '0;
          state <= SHIFT;
        end else begin
          tmr <= tmr + 1'b1;
        end
        SHIFT: if (sh_last) begin
          tmr   <= '0;
          state <= HOLD;
        end
        HOLD: if (tmr == TW'(CS_HOLD - 1)) begin
          tmr   <= '0;
          cs_n  <= 1'b1;
          done  <= 1'b1;
          state <= GAP;
        end else begin
          tmr <= tmr + 1'b1;
        end
        GAP: if (tmr == TW'(IDLE_GAP - 1)) begin
          tmr   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end else begin
          tmr <= tmr + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
